// File: rtl/exc_ctrl_pkg.sv
// Shared CP0-side definitions: FSM encoding, trap cause codes, status bit
// positions and the trap priority encoder.
package exc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAVE  = 2'd1,
    ST_REDIR = 2'd2,
    ST_ERET  = 2'd3
  } exc_state_e;

  localparam logic [31:0] DEF_HANDLER_ADDR  = 32'h0040_0004;
  localparam logic [4:0]  DEF_CAUSE_SYSCALL = 5'd8;
  localparam logic [4:0]  DEF_CAUSE_BREAK   = 5'd9;
  localparam logic [4:0]  DEF_CAUSE_TEQ     = 5'd13;

  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_SYS = 1;
  localparam int unsigned STATUS_BRK = 2;
  localparam int unsigned STATUS_TEQ = 3;

  // Fixed priority syscall > break > teq; inputs are already status-qualified.
  function automatic logic [4:0] trap_cause(
    input logic       sys_ok,
    input logic       brk_ok,
    input logic [4:0] c_sys,
    input logic [4:0] c_brk,
    input logic [4:0] c_teq
  );
    if (sys_ok)      return c_sys;
    else if (brk_ok) return c_brk;
    else             return c_teq;
  endfunction

endpackage

// File: rtl/exc_ctrl.sv
// Exception sequencer: accepts status-qualified trap/eret requests in IDLE and
// walks CP0 through the save/redirect or eret sequence while stalling the core.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR  = DEF_HANDLER_ADDR,
  parameter logic [4:0]  CAUSE_SYSCALL = DEF_CAUSE_SYSCALL,
  parameter logic [4:0]  CAUSE_BREAK   = DEF_CAUSE_BREAK,
  parameter logic [4:0]  CAUSE_TEQ     = DEF_CAUSE_TEQ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_req,
  input  logic        break_req,
  input  logic        teq_req,
  input  logic        eret_req,
  input  logic [31:0] status,
  input  logic [31:0] epc,
  output logic        exception,
  output logic [4:0]  cause,
  output logic        eret,
  output logic        pc_we,
  output logic [31:0] pc_next,
  output logic        stall
);

  exc_state_e state_q, state_d;
  logic [4:0] cause_q, cause_d;

  logic sys_ok, brk_ok, teq_ok, trap_any;

  // Only the enable bits matter; the rest of the status word belongs to CP0.
  logic unused_status;
  assign unused_status = ^status[31:4];

  assign sys_ok   = status[STATUS_IE] & status[STATUS_SYS] & syscall_req;
  assign brk_ok   = status[STATUS_IE] & status[STATUS_BRK] & break_req;
  assign teq_ok   = status[STATUS_IE] & status[STATUS_TEQ] & teq_req;
  assign trap_any = sys_ok | brk_ok | teq_ok;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trap_any) begin
          state_d = ST_SAVE;
          cause_d = trap_cause(sys_ok, brk_ok, CAUSE_SYSCALL, CAUSE_BREAK, CAUSE_TEQ);
        end else if (eret_req) begin
          state_d = ST_ERET;
        end
      end
      ST_SAVE:  state_d = ST_REDIR;
      ST_REDIR: state_d = ST_IDLE;
      ST_ERET:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Moore decode, gated by rst so a reset cycle never carries a partial strobe.
  always_comb begin
    exception = 1'b0;
    eret      = 1'b0;
    pc_we     = 1'b0;
    pc_next   = '0;
    stall     = 1'b0;
    cause     = '0;
    if (!rst) begin
      cause = cause_q;
      unique case (state_q)
        ST_SAVE: begin
          exception = 1'b1;
          stall     = 1'b1;
        end
        ST_REDIR: begin
          pc_we   = 1'b1;
          pc_next = HANDLER_ADDR;
          stall   = 1'b1;
        end
        ST_ERET: begin
          eret    = 1'b1;
          pc_we   = 1'b1;
          pc_next = epc;
          stall   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus random traffic,
// all compared against a queue-based model of the pending CP0 sequence.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        syscall_req, break_req, teq_req, eret_req;
  logic [31:0] status, epc;
  logic        exception, eret, pc_we, stall;
  logic [4:0]  cause;
  logic [31:0] pc_next;

  int n_vec = 0;
  int n_err = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst),
    .syscall_req(syscall_req), .break_req(break_req), .teq_req(teq_req),
    .eret_req(eret_req), .status(status), .epc(epc),
    .exception(exception), .cause(cause), .eret(eret),
    .pc_we(pc_we), .pc_next(pc_next), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: a queue of the cycles still owed to CP0 after an accepted request.
  typedef enum {K_SAVE, K_REDIR, K_ERET} kind_e;
  kind_e      mq[$];
  logic [4:0] m_cause = 5'd0;

  function automatic logic [40:0] obs();
    return {exception, cause, eret, pc_we, pc_next, stall};
  endfunction

  function automatic logic [40:0] model_exp();
    logic e, r, w, s;
    logic [31:0] pn;
    e = 0; r = 0; w = 0; s = 0; pn = 32'h0;
    if (rst) return 41'h0;
    if (mq.size() > 0) begin
      s = 1;
      case (mq[0])
        K_SAVE:  e = 1;
        K_REDIR: begin w = 1; pn = 32'h0040_0004; end
        K_ERET:  begin r = 1; w = 1; pn = epc; end
        default: ;
      endcase
    end
    return {e, m_cause, r, w, pn, s};
  endfunction

  task automatic model_update();
    if (rst) begin
      mq.delete();
      m_cause = 5'd0;
    end else if (mq.size() == 0) begin
      if (status[0] && status[1] && syscall_req) begin
        mq.push_back(K_SAVE); mq.push_back(K_REDIR); m_cause = 5'd8;
      end else if (status[0] && status[2] && break_req) begin
        mq.push_back(K_SAVE); mq.push_back(K_REDIR); m_cause = 5'd9;
      end else if (status[0] && status[3] && teq_req) begin
        mq.push_back(K_SAVE); mq.push_back(K_REDIR); m_cause = 5'd13;
      end else if (eret_req) begin
        mq.push_back(K_ERET);
      end
    end else begin
      void'(mq.pop_front());
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic set_in(input logic s, input logic b, input logic t, input logic e,
                        input logic [31:0] st, input logic [31:0] ep, input logic r);
    syscall_req = s; break_req = b; teq_req = t; eret_req = e;
    status = st; epc = ep; rst = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 1, 32'h1F, 32'hDEAD_BEEF, 1);
      n_vec++;
      if (obs() !== 41'h0) begin
        n_err++; $display("FAIL reset_hold cyc%0d got=%h want=0", i, obs());
      end
      tick();
    end
    set_in(0, 0, 0, 0, 32'h1F, 32'h0, 0);
    n_vec++;
    if (obs() !== 41'h0) begin
      n_err++; $display("FAIL reset_release got=%h want=0", obs());
    end
    tick();
  endtask

  task automatic test_syscall();
    set_in(1, 0, 0, 0, 32'h1F, 32'h0, 0);
    tick();
    set_in(0, 0, 0, 0, 32'h1F, 32'h0, 0);
    n_vec++;
    if ({exception, cause, stall, pc_we} !== {1'b1, 5'd8, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL sys_save got exc=%b cause=%0d stall=%b pc_we=%b want 1/8/1/0",
                        exception, cause, stall, pc_we);
    end
    tick();
    n_vec++;
    if ({pc_we, pc_next, stall, exception} !== {1'b1, 32'h0040_0004, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL sys_redir got pc_we=%b pc_next=%h stall=%b exc=%b want 1/00400004/1/0",
                        pc_we, pc_next, stall, exception);
    end
    tick();
    n_vec++;
    if (obs() !== model_exp() || stall !== 1'b0) begin
      n_err++; $display("FAIL sys_idle got=%h want=%h", obs(), model_exp());
    end
    tick();
  endtask

  task automatic test_masked();
    logic [31:0] st_tab [2];
    st_tab[0] = 32'h1D;
    st_tab[1] = 32'h1E;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        set_in(1, 0, 0, 0, st_tab[k], 32'h0, 0);
        n_vec++;
        if ({exception, pc_we, stall} !== 3'b000 || obs() !== model_exp()) begin
          n_err++; $display("FAIL masked st=%h cyc%0d got=%h want=%h", st_tab[k], i, obs(), model_exp());
        end
        tick();
      end
    end
  endtask

  task automatic test_priority();
    logic [2:0] req_tab [3];
    logic [4:0] exp_tab [3];
    req_tab[0] = 3'b111; exp_tab[0] = 5'd8;
    req_tab[1] = 3'b011; exp_tab[1] = 5'd9;
    req_tab[2] = 3'b001; exp_tab[2] = 5'd13;
    for (int k = 0; k < 3; k++) begin
      set_in(req_tab[k][2], req_tab[k][1], req_tab[k][0], 0, 32'h1F, 32'h0, 0);
      tick();
      set_in(0, 0, 0, 0, 32'h1F, 32'h0, 0);
      n_vec++;
      if (exception !== 1'b1 || cause !== exp_tab[k]) begin
        n_err++; $display("FAIL prio req=%b got exc=%b cause=%0d want 1/%0d",
                          req_tab[k], exception, cause, exp_tab[k]);
      end
      for (int i = 0; i < 2; i++) begin
        tick();
        n_vec++;
        if (obs() !== model_exp()) begin
          n_err++; $display("FAIL prio_tail req=%b cyc%0d got=%h want=%h", req_tab[k], i, obs(), model_exp());
        end
      end
      tick();
    end
  endtask

  task automatic test_eret();
    set_in(0, 0, 0, 1, 32'h1F, 32'h0040_0120, 0);
    tick();
    set_in(0, 0, 0, 0, 32'h1F, 32'h0040_0120, 0);
    n_vec++;
    if ({eret, pc_we, stall, exception, pc_next} !== {4'b1110, 32'h0040_0120}) begin
      n_err++; $display("FAIL eret_cycle got eret=%b pc_we=%b stall=%b exc=%b pc_next=%h want 1/1/1/0/00400120",
                        eret, pc_we, stall, exception, pc_next);
    end
    tick();
    n_vec++;
    if (obs() !== model_exp() || stall !== 1'b0) begin
      n_err++; $display("FAIL eret_idle got=%h want=%h", obs(), model_exp());
    end
    tick();
  endtask

  task automatic test_trap_over_eret();
    int eret_seen = 0;
    set_in(0, 1, 0, 1, 32'h1F, 32'h0040_0120, 0);
    tick();
    set_in(0, 0, 0, 0, 32'h1F, 32'h0040_0120, 0);
    n_vec++;
    if (exception !== 1'b1 || cause !== 5'd9) begin
      n_err++; $display("FAIL trap_over_eret got exc=%b cause=%0d want 1/9", exception, cause);
    end
    for (int i = 0; i < 3; i++) begin
      if (eret) eret_seen++;
      tick();
    end
    n_vec++;
    if (eret_seen !== 0) begin
      n_err++; $display("FAIL dropped_eret got %0d eret pulses want 0", eret_seen);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 2; k++) begin
      set_in(1, 0, 0, 0, 32'h1F, 32'h0, 0);
      for (int i = 0; i < k; i++) begin
        tick();
        set_in(0, 0, 0, 0, 32'h1F, 32'h0, 0);
      end
      set_in(0, 0, 0, 0, 32'h1F, 32'h0, 1);
      n_vec++;
      if (obs() !== 41'h0) begin
        n_err++; $display("FAIL rst_during_state%0d got=%h want=0", k, obs());
      end
      tick();
      set_in(0, 0, 0, 0, 32'h1F, 32'h0, 0);
      n_vec++;
      if (obs() !== 41'h0 || obs() !== model_exp()) begin
        n_err++; $display("FAIL rst_after_state%0d got=%h want=0", k, obs());
      end
      tick();
    end
  endtask

  task automatic test_ignore_busy();
    int pulses = 0;
    set_in(1, 0, 0, 0, 32'h1F, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) set_in(0, 0, 0, 0, 32'h1F, 32'h0, 0);
      else if (i > 0) set_in(1, 1, 1, 1, 32'h1F, 32'h0, 0);
      if (exception) pulses++;
      n_vec++;
      if (obs() !== model_exp()) begin
        n_err++; $display("FAIL busy cyc%0d got=%h want=%h", i, obs(), model_exp());
      end
      tick();
    end
    n_vec++;
    if (pulses !== 1) begin
      n_err++; $display("FAIL busy_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
             {$urandom_range(0, 255), 4'h0} | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'hF),
             $urandom, ($urandom_range(0, 24) == 0));
      n_vec++;
      if (obs() !== model_exp()) begin
        n_err++; $display("FAIL random cyc%0d got=%h want=%h", i, obs(), model_exp());
      end
      tick();
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0, 32'h0, 32'h0, 1);
    @(negedge clk);
    test_reset();
    test_syscall();
    test_masked();
    test_priority();
    test_eret();
    test_trap_over_eret();
    test_reset_mid();
    test_ignore_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
